ifft_sym_ctrl: RTL and testbench

Per-symbol sequencer for the PUSCH IFFT+CP chain.
- Admits exactly N frequency-domain samples into the radix-2 first stage.
- Holds off upstream while the IFFT pipeline drains.
- Generates CP-then-body read addresses for the IFFT output buffer, with the CP length chosen per symbol index within a slot.
- Sits between the resource-mapper output and the R2/R4 IFFT pipeline/output RAM.
- One symbol in flight at a time.

---
 rtl/ifft_pkg.sv | 26 ++
 rtl/ifft_sym_ctrl_if.sv | 41 ++++
 rtl/ifft_cp_addr_gen.sv | 59 +++++
 rtl/ifft_sym_ctrl.sv | 118 +++++++++++
 tb/tb_ifft_sym_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/ifft_pkg.sv
// Shared definitions for the PUSCH IFFT+CP symbol sequencer.
// Optional watchdog in the top is enabled with IFFT_WATCHDOG_EN.
package ifft_pkg;

  localparam int N        = 2048;
  localparam int LOG2N    = 11;
  localparam int CP_LONG  = 160;
  localparam int CP_SHORT = 144;
  localparam int SYMS     = 14;

  typedef logic [LOG2N-1:0] addr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_EMIT_CP,
    S_EMIT_SYM
  } state_t;

  // Symbols 0 and 7 of a slot carry the long cyclic prefix.
  function automatic addr_t cp_len_of(input logic [3:0] sym);
    return ((sym == 4'd0) || (sym == 4'd7)) ? addr_t'(CP_LONG) : addr_t'(CP_SHORT);
  endfunction

endpackage

// File: rtl/ifft_sym_ctrl_if.sv
// Handshake/bus bundle between resource mapper, IFFT pipeline and output reader.
// err_timeout exists only when IFFT_WATCHDOG_EN is defined.
interface ifft_sym_ctrl_if;
  import ifft_pkg::*;

  logic       slot_start;
  logic       in_valid;
  logic       in_ready;
  logic       fft_valid;
  addr_t      fft_idx;
  logic       ifft_done;
  logic       rd_en;
  addr_t      rd_addr;
  logic       out_sos;
  logic [3:0] sym_idx;
  logic       busy;
  logic       err_drop;
  logic       err_spur;
`ifdef IFFT_WATCHDOG_EN
  logic       err_timeout;
`endif

  modport master (
`ifdef IFFT_WATCHDOG_EN
    input  err_timeout,
`endif
    output slot_start, in_valid, ifft_done,
    input  in_ready, fft_valid, fft_idx, rd_en, rd_addr, out_sos,
    input  sym_idx, busy, err_drop, err_spur
  );

  modport slave (
`ifdef IFFT_WATCHDOG_EN
    output err_timeout,
`endif
    input  slot_start, in_valid, ifft_done,
    output in_ready, fft_valid, fft_idx, rd_en, rd_addr, out_sos,
    output sym_idx, busy, err_drop, err_spur
  );

endinterface

// File: rtl/ifft_cp_addr_gen.sv
// Output-buffer read sequencer: CP tail first, then the full symbol body.
// Reports the last CP cycle and the last body cycle back to the controlling FSM.
module ifft_cp_addr_gen
  import ifft_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  addr_t cp_len,
  output logic  rd_en,
  output addr_t rd_addr,
  output logic  out_sos,
  output logic  cp_last,
  output logic  sym_last
);

  logic  in_cp;
  addr_t cnt;
  addr_t cp_len_q;

  assign cp_last  = rd_en && in_cp && (cnt == cp_len_q - 1'b1);
  assign sym_last = rd_en && !in_cp && (cnt == addr_t'(N - 1));

  // rd_addr simply increments across the CP -> body seam except where it restarts at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      out_sos  <= 1'b0;
      in_cp    <= 1'b0;
      cnt      <= '0;
      cp_len_q <= '0;
    end else begin
      out_sos <= 1'b0;
      if (start) begin
        rd_en    <= 1'b1;
        rd_addr  <= addr_t'(N - int'(cp_len));
        out_sos  <= 1'b1;
        in_cp    <= 1'b1;
        cnt      <= '0;
        cp_len_q <= cp_len;
      end else if (rd_en) begin
        if (cp_last) begin
          in_cp   <= 1'b0;
          cnt     <= '0;
          rd_addr <= '0;
        end else if (sym_last) begin
          rd_en   <= 1'b0;
          cnt     <= '0;
          rd_addr <= '0;
        end else begin
          cnt     <= cnt + 1'b1;
          rd_addr <= rd_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ifft_sym_ctrl.sv
// Per-symbol sequencer for the PUSCH IFFT+CP chain (load, drain, CP+body readout).
// Define IFFT_WATCHDOG_EN to add err_timeout and a bounded WAIT (parameter TIMEOUT).
module ifft_sym_ctrl
  import ifft_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  ifft_sym_ctrl_if.slave bus
);

`ifdef IFFT_WATCHDOG_EN
  parameter int TIMEOUT = 16384;
  localparam int WW = $clog2(TIMEOUT + 1);
`endif

  state_t     state, state_nxt;
  addr_t      load_cnt;
  logic [3:0] sym_idx_q;
  logic       slot_pend;
  logic       accept;
  logic       start;
  logic       cp_last;
  logic       sym_last;
  logic       timeout;

  // in_ready is gated by reset so every output reads 0 while reset is held.
  assign bus.in_ready  = rst && ((state == S_IDLE) || (state == S_LOAD));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.fft_valid = accept;
  assign bus.fft_idx   = load_cnt;
  assign bus.busy      = (state != S_IDLE);
  assign bus.sym_idx   = sym_idx_q;
  assign start         = (state == S_WAIT) && bus.ifft_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept) state_nxt = S_LOAD;
      S_LOAD:     if (accept && (load_cnt == addr_t'(N - 1))) state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.ifft_done) state_nxt = S_EMIT_CP;
        else if (timeout)  state_nxt = S_IDLE;
      end
      S_EMIT_CP:  if (cp_last)  state_nxt = S_EMIT_SYM;
      S_EMIT_SYM: if (sym_last) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // A pending slot_start (or one arriving with the first sample) restarts the slot at index 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt  <= '0;
      sym_idx_q <= '0;
      slot_pend <= 1'b0;
    end else begin
      if ((state == S_IDLE) && accept) begin
        load_cnt  <= addr_t'(1);
        slot_pend <= 1'b0;
        if (slot_pend || bus.slot_start) sym_idx_q <= '0;
      end else begin
        if (bus.slot_start) slot_pend <= 1'b1;
        if ((state == S_LOAD) && accept) begin
          load_cnt <= (load_cnt == addr_t'(N - 1)) ? '0 : load_cnt + 1'b1;
        end
        if ((state == S_EMIT_SYM) && sym_last) begin
          sym_idx_q <= (sym_idx_q == 4'(SYMS - 1)) ? 4'd0 : sym_idx_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.err_drop <= 1'b0;
      bus.err_spur <= 1'b0;
    end else begin
      if (bus.in_valid && !bus.in_ready)           bus.err_drop <= 1'b1;
      if (bus.ifft_done && (state != S_WAIT))      bus.err_spur <= 1'b1;
    end
  end

`ifdef IFFT_WATCHDOG_EN
  logic [WW-1:0] wait_cnt;

  assign timeout = (state == S_WAIT) && !bus.ifft_done && (wait_cnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt        <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      if (timeout) bus.err_timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  ifft_cp_addr_gen u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cp_len   (cp_len_of(sym_idx_q)),
    .rd_en    (bus.rd_en),
    .rd_addr  (bus.rd_addr),
    .out_sos  (bus.out_sos),
    .cp_last  (cp_last),
    .sym_last (sym_last)
  );

endmodule

// File: tb/tb_ifft_sym_ctrl.sv
// Self-checking bench for ifft_sym_ctrl: randomized load gaps against a slot/CP reference model.
// Expected readout is derived from symbol index rules, not from the RTL structure.
module tb_ifft_sym_ctrl;
  import ifft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  ifft_sym_ctrl_if bus();

  ifft_sym_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int num_checks = 0;
  int num_fail   = 0;

  // Reference model of the slot bookkeeping.
  int model_next = 0;
  bit model_pend = 1'b0;
  int cur_idx    = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int cpFor(input int idx);
    return (idx == 0 || idx == 7) ? CP_LONG : CP_SHORT;
  endfunction

  task automatic applyStimulus(input bit gaps, input int spur_at);
    int acc = 0;
    int cyc = 0;
    while (acc < N && cyc < 8 * N) begin
      @(negedge clk);
      bus.in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.ifft_done = (cyc == spur_at);
      #1;
      if (bus.in_valid) begin
        if (acc == 0) begin
          cur_idx    = model_pend ? 0 : model_next;
          model_pend = 1'b0;
        end
        checkOutput("fft_valid", bus.fft_valid, 1);
        checkOutput("fft_idx", bus.fft_idx, acc);
        acc++;
      end else begin
        checkOutput("fft_valid_gap", bus.fft_valid, 0);
      end
      cyc++;
    end
    if (acc < N) checkOutput("load_budget", acc, N);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.ifft_done = 1'b0;
    #1;
    checkOutput("in_ready_after_load", bus.in_ready, 0);
    checkOutput("busy_in_wait", bus.busy, 1);
    checkOutput("sym_idx_loaded", bus.sym_idx, cur_idx);
  endtask

  task automatic waitIfft(input int delay, input bit hold_valid);
    repeat (delay) begin
      @(negedge clk);
      bus.in_valid = hold_valid;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    if (hold_valid) begin
      checkOutput("err_drop_set", bus.err_drop, 1);
      checkOutput("in_ready_wait", bus.in_ready, 0);
      checkOutput("busy_after_drop", bus.busy, 1);
      checkOutput("rd_en_after_drop", bus.rd_en, 0);
    end
    bus.ifft_done = 1'b1;
  endtask

  task automatic emitSymbol(input int slot_at, input bit slot_last, input int reset_addr);
    int cp  = cpFor(cur_idx);
    int len = cp + N;
    int s_at = slot_last ? len - 1 : slot_at;
    int r_at = (reset_addr >= 0) ? cp + reset_addr : -1;
    int exp_addr;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      bus.ifft_done  = 1'b0;
      bus.slot_start = (i == s_at);
      if (i == s_at) model_pend = 1'b1;
      if (i == r_at) begin
        checkOutput("rd_addr_before_reset", bus.rd_addr, reset_addr);
        rst = 1'b0;
        #1;
        bus.slot_start = 1'b0;
        checkOutput("rst_rd_en", bus.rd_en, 0);
        checkOutput("rst_rd_addr", bus.rd_addr, 0);
        checkOutput("rst_out_sos", bus.out_sos, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_sym_idx", bus.sym_idx, 0);
        model_next = 0;
        model_pend = 1'b0;
        return;
      end
      exp_addr = (i < cp) ? (N - cp + i) : (i - cp);
      checkOutput("rd_en", bus.rd_en, 1);
      checkOutput("rd_addr", bus.rd_addr, exp_addr);
      checkOutput("out_sos", bus.out_sos, (i == 0) ? 1 : 0);
      if (i == 0) checkOutput("sym_idx_emit", bus.sym_idx, cur_idx);
    end
    @(negedge clk);
    bus.slot_start = 1'b0;
    model_next = (cur_idx + 1) % SYMS;
    #1;
    checkOutput("rd_en_end", bus.rd_en, 0);
    checkOutput("busy_end", bus.busy, 0);
    checkOutput("in_ready_idle", bus.in_ready, 1);
    checkOutput("sym_idx_next", bus.sym_idx, model_next);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got %0d checks, expected completion", num_checks);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    bus.slot_start = 1'b0;
    bus.in_valid   = 1'b0;
    bus.ifft_done  = 1'b0;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    checkOutput("reset_in_ready", bus.in_ready, 0);
    checkOutput("reset_fft_valid", bus.fft_valid, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_rd_en", bus.rd_en, 0);
    checkOutput("reset_sym_idx", bus.sym_idx, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("post_reset_in_ready", bus.in_ready, 1);
    checkOutput("post_reset_err_drop", bus.err_drop, 0);
    checkOutput("post_reset_err_spur", bus.err_spur, 0);

    for (int s = 0; s < 18; s++) begin
      if (s == 1) begin
        checkOutput("err_spur_clean", bus.err_spur, 0);
        checkOutput("err_drop_clean", bus.err_drop, 0);
        @(negedge clk);
        bus.ifft_done = 1'b1;
        @(negedge clk);
        bus.ifft_done = 1'b0;
        #1;
        checkOutput("err_spur_idle", bus.err_spur, 1);
        checkOutput("busy_after_spur", bus.busy, 0);
      end
      applyStimulus(s == 1, (s == 1) ? 100 : -1);
      waitIfft((s == 0) ? 50 : 3, s == 2);
      emitSymbol((s == 15) ? 10 : -1, s == 16, (s == 17) ? 1000 : -1);
      if (s == 2) checkOutput("err_spur_sticky", bus.err_spur, 1);
      if (s == 13) checkOutput("sym_idx_wrap", bus.sym_idx, 0);
    end

    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("after_abort_in_ready", bus.in_ready, 1);
    checkOutput("after_abort_sym_idx", bus.sym_idx, 0);
    checkOutput("after_abort_err_spur", bus.err_spur, 0);
    checkOutput("after_abort_err_drop", bus.err_drop, 0);

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
    $finish;
  end

endmodule
